// File: rtl/cache_mem_arbiter.sv
// Arbiter between the split L1 caches and the single burst memory port:
// grants one 256-bit line request at a time and moves it as 4 x 64-bit beats.
module cache_mem_arbiter #(
  parameter int BEATS      = 4,
  parameter int BEAT_WIDTH = 64,
  parameter int LINE_WIDTH = BEATS * BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  icache_pmem_read,
  input  logic [31:0]           icache_pmem_address,
  output logic [LINE_WIDTH-1:0] icache_pmem_rdata,
  output logic                  icache_pmem_resp,

  input  logic                  dcache_pmem_read,
  input  logic                  dcache_pmem_write,
  input  logic [31:0]           dcache_pmem_address,
  input  logic [LINE_WIDTH-1:0] dcache_pmem_wdata,
  output logic [LINE_WIDTH-1:0] dcache_pmem_rdata,
  output logic                  dcache_pmem_resp,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [31:0]           mem_address,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int BEAT_BITS   = $clog2(BEATS);
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);

  typedef enum logic [2:0] {
    IDLE,
    I_READ,
    D_READ,
    D_WRITE,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [BEAT_BITS-1:0]   beat_q, beat_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;
  logic [31:0]            addr_q, addr_d;
  logic                   dgrant_q, dgrant_d;
  logic                   last_beat;
  logic                   unused_offset_bits;

  assign last_beat = (beat_q == BEAT_BITS'(BEATS - 1));

  // Byte offset within the line is dropped: bursts are always line-aligned.
  assign unused_offset_bits = ^{icache_pmem_address[OFFSET_BITS-1:0],
                                dcache_pmem_address[OFFSET_BITS-1:0]};

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its _d value from before the edge.
  // NOTE: the line buffer is a plain register, not a RAM, so it can and does
  // clear on reset; the rdata buses must read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      line_q   <= '0;
      addr_q   <= '0;
      dgrant_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      line_q   <= line_d;
      addr_q   <= addr_d;
      dgrant_q <= dgrant_d;
    end
  end

  // NOTE: every _d signal gets its hold value first, so no path through the
  // case below can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    line_d   = line_q;
    addr_d   = addr_q;
    dgrant_d = dgrant_q;

    case (state_q)
      IDLE: begin
        // Fixed priority: dcache writeback, dcache fill, then icache fill.
        if (dcache_pmem_write) begin
          state_d  = D_WRITE;
          addr_d   = {dcache_pmem_address[31:OFFSET_BITS], OFFSET_BITS'(0)};
          line_d   = dcache_pmem_wdata;
          dgrant_d = 1'b1;
        end else if (dcache_pmem_read) begin
          state_d  = D_READ;
          addr_d   = {dcache_pmem_address[31:OFFSET_BITS], OFFSET_BITS'(0)};
          dgrant_d = 1'b1;
        end else if (icache_pmem_read) begin
          state_d  = I_READ;
          addr_d   = {icache_pmem_address[31:OFFSET_BITS], OFFSET_BITS'(0)};
          dgrant_d = 1'b0;
        end
      end

      I_READ, D_READ: begin
        if (mem_resp) begin
          line_d[beat_q*BEAT_WIDTH +: BEAT_WIDTH] = mem_rdata;
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
            beat_d  = '0;
          end
        end
      end

      D_WRITE: begin
        if (mem_resp) begin
          beat_d = beat_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
            beat_d  = '0;
          end
        end
      end

      // One-cycle response; requests are not looked at here so a cache that
      // drops its request this cycle is never served twice.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_read    = (state_q == I_READ) || (state_q == D_READ);
  assign mem_write   = (state_q == D_WRITE);
  assign mem_address = addr_q;
  assign mem_wdata   = mem_write ? line_q[beat_q*BEAT_WIDTH +: BEAT_WIDTH] : '0;

  assign icache_pmem_resp  = (state_q == DONE) && !dgrant_q;
  assign dcache_pmem_resp  = (state_q == DONE) &&  dgrant_q;
  assign icache_pmem_rdata = line_q;
  assign dcache_pmem_rdata = line_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: a behavioural burst memory plus a
// scoreboard of expected cache responses, driven from a vector table.
module tb_cache_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         icache_pmem_read;
  logic [31:0]  icache_pmem_address;
  logic [255:0] icache_pmem_rdata;
  logic         icache_pmem_resp;
  logic         dcache_pmem_read;
  logic         dcache_pmem_write;
  logic [31:0]  dcache_pmem_address;
  logic [255:0] dcache_pmem_wdata;
  logic [255:0] dcache_pmem_rdata;
  logic         dcache_pmem_resp;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  cache_mem_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .icache_pmem_read   (icache_pmem_read),
    .icache_pmem_address(icache_pmem_address),
    .icache_pmem_rdata  (icache_pmem_rdata),
    .icache_pmem_resp   (icache_pmem_resp),
    .dcache_pmem_read   (dcache_pmem_read),
    .dcache_pmem_write  (dcache_pmem_write),
    .dcache_pmem_address(dcache_pmem_address),
    .dcache_pmem_wdata  (dcache_pmem_wdata),
    .dcache_pmem_rdata  (dcache_pmem_rdata),
    .dcache_pmem_resp   (dcache_pmem_resp),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_address        (mem_address),
    .mem_wdata          (mem_wdata),
    .mem_rdata          (mem_rdata),
    .mem_resp           (mem_resp)
  );

  typedef struct {
    bit           is_d;
    bit           is_w;
    bit           rd_too;
    bit           preload;
    logic [31:0]  addr;
    logic [31:0]  exp_addr;
    logic [255:0] line;
    bit   [6:0]   pat;
  } vec_t;

  typedef struct {
    bit           is_d;
    bit           is_w;
    logic [31:0]  addr;
    logic [255:0] line;
  } exp_t;

  typedef struct {
    bit           is_w;
    logic [31:0]  addr;
    logic [255:0] line;
    int           start_cyc;
    int           end_cyc;
  } rec_t;

  localparam logic [255:0] L_I  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                   64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] L_W  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                   64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
  localparam logic [255:0] L_G  = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                   64'hDEAD_BEEF_CAFE_F00D, 64'h0F1E_2D3C_4B5A_6978};
  localparam logic [255:0] L_G2 = {64'hA5A5_A5A5_A5A5_A5A5, 64'h5A5A_5A5A_5A5A_5A5A,
                                   64'h0000_FFFF_0000_FFFF, 64'hFFFF_0000_FFFF_0000};
  localparam int NV = 7;

  exp_t         exp_q[$];
  rec_t         done_q[$];
  logic [255:0] mem_lines [logic [31:0]];
  bit   [6:0]   gap_pat;
  int           mcnt;
  int           cyc;
  int           n_checks;
  int           n_fail;
  int           resp_cyc_of[2];
  int           start_cyc_of[2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Burst memory: answers on the gap pattern, serves reads from mem_lines and
  // collects written beats; each finished burst is recorded in done_q.
  initial begin : mem_model
    int   pidx;
    bit   active;
    rec_t cur;
    logic [255:0] rl;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    mcnt      = 0;
    pidx      = 0;
    active    = 1'b0;
    forever begin
      @(negedge clk);
      mem_rdata = {$urandom, $urandom};
      if (rst || !(mem_read || mem_write)) begin
        mem_resp = 1'b0;
        mcnt     = 0;
        pidx     = 0;
        active   = 1'b0;
      end else begin
        if (!active) begin
          active        = 1'b1;
          cur.start_cyc = cyc;
          cur.addr      = mem_address;
          cur.is_w      = mem_write;
          cur.line      = '0;
        end
        check("mem_addr_stable", mem_address, cur.addr);
        mem_resp = gap_pat[pidx];
        pidx     = (pidx == 6) ? 0 : pidx + 1;
        if (mem_resp) begin
          if (mem_write) begin
            cur.line[mcnt*64 +: 64] = mem_wdata;
          end else begin
            rl = mem_lines.exists(cur.addr) ? mem_lines[cur.addr] : '0;
            mem_rdata = rl[mcnt*64 +: 64];
            cur.line[mcnt*64 +: 64] = mem_rdata;
          end
          mcnt++;
          if (mcnt == 4) begin
            cur.end_cyc = cyc;
            if (cur.is_w) mem_lines[cur.addr] = cur.line;
            done_q.push_back(cur);
          end
        end
      end
    end
  end

  // Waits for every queued response, checking each against the scoreboard and
  // dropping the served cache's request in its response cycle.
  task automatic run_txns(input int budget);
    int   n;
    bit   d;
    exp_t e;
    rec_t r;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        n_checks++;
        n_fail++;
        $display("FAIL txn_timeout: %0d responses outstanding after %0d cycles", exp_q.size(), budget);
        exp_q.delete();
        break;
      end
      check("resp_exclusive", icache_pmem_resp && dcache_pmem_resp, 1'b0);
      if (icache_pmem_resp || dcache_pmem_resp) begin
        d = dcache_pmem_resp;
        e = exp_q.pop_front();
        check("resp_owner", d, e.is_d);
        check("mem_idle_at_resp", {mem_read, mem_write}, 2'b00);
        if (done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL burst_missing: got resp without 4 memory beats, expected a full burst");
        end else begin
          r = done_q.pop_front();
          check("burst_addr", r.addr, e.addr);
          check("burst_kind", r.is_w, e.is_w);
          check("resp_latency", cyc, r.end_cyc + 1);
          if (e.is_w) check("written_line", r.line, e.line);
          resp_cyc_of[d]  = cyc;
          start_cyc_of[d] = r.start_cyc;
        end
        if (!e.is_w) check(d ? "dcache_rdata" : "icache_rdata",
                           d ? dcache_pmem_rdata : icache_pmem_rdata, e.line);
        if (d) begin
          dcache_pmem_read  = 1'b0;
          dcache_pmem_write = 1'b0;
        end else begin
          icache_pmem_read = 1'b0;
        end
      end
    end
    @(negedge clk);
    check("resp_single_pulse", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
  endtask

  initial begin
    vec_t vecs[NV];
    vec_t v;
    exp_t e;
    int   k;

    vecs[0] = '{0, 0, 0, 1, 32'h0000_1234, 32'h0000_1220, L_I,  7'b1111111};
    vecs[1] = '{1, 1, 0, 0, 32'h8000_0060, 32'h8000_0060, L_W,  7'b1111111};
    vecs[2] = '{1, 0, 0, 0, 32'h8000_007F, 32'h8000_0060, L_W,  7'b1011001};
    vecs[3] = '{0, 0, 0, 1, 32'h0000_0500, 32'h0000_0500, L_G,  7'b1011001};
    vecs[4] = '{1, 1, 1, 0, 32'h0000_1F04, 32'h0000_1F00, L_G2, 7'b0100101};
    vecs[5] = '{0, 0, 0, 0, 32'h0000_1F1C, 32'h0000_1F00, L_G2, 7'b1111111};
    vecs[6] = '{1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFE0, L_G,  7'b1111111};

    n_checks = 0;
    n_fail   = 0;
    gap_pat  = 7'b1111111;
    rst                 = 1'b1;
    icache_pmem_read    = 1'b0;
    icache_pmem_address = '0;
    dcache_pmem_read    = 1'b0;
    dcache_pmem_write   = 1'b0;
    dcache_pmem_address = '0;
    dcache_pmem_wdata   = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_mem_ctrl", {mem_read, mem_write, icache_pmem_resp, dcache_pmem_resp}, 4'b0000);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_mem_wdata", mem_wdata, 64'h0);
    check("rst_icache_rdata", icache_pmem_rdata, 256'h0);
    check("rst_dcache_rdata", dcache_pmem_rdata, 256'h0);
    rst = 1'b0;
    @(negedge clk);

    // Vector table: one transaction per row, in isolation
    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      gap_pat = v.pat;
      if (v.preload) mem_lines[v.exp_addr] = v.line;
      if (v.is_d) begin
        dcache_pmem_read    = !v.is_w || v.rd_too;
        dcache_pmem_write   = v.is_w;
        dcache_pmem_address = v.addr;
        dcache_pmem_wdata   = v.is_w ? v.line : '0;
      end else begin
        icache_pmem_read    = 1'b1;
        icache_pmem_address = v.addr;
      end
      e = '{v.is_d, v.is_w, v.exp_addr, v.line};
      exp_q.push_back(e);
      run_txns(200);
    end

    // Simultaneous requests: dcache first, icache burst two cycles after its resp
    gap_pat = 7'b1111111;
    mem_lines[32'h0000_2000] = L_G;
    mem_lines[32'h0000_3000] = L_I;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 32'h0000_2008;
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 32'h0000_3010;
    e = '{1'b1, 1'b0, 32'h0000_2000, L_G};
    exp_q.push_back(e);
    e = '{1'b0, 1'b0, 32'h0000_3000, L_I};
    exp_q.push_back(e);
    run_txns(300);
    check("icache_burst_start", start_cyc_of[0], resp_cyc_of[1] + 2);

    // Reset in the middle of a dcache read, after beat 1 has been accepted
    mem_lines[32'h0000_4000] = L_G;
    mem_lines[32'h0000_0040] = L_I;
    dcache_pmem_read    = 1'b1;
    dcache_pmem_address = 32'h0000_4000;
    k = 0;
    while (mcnt < 2 && k < 50) begin
      @(posedge clk);
      k++;
    end
    check("midburst_reached_beat1", mcnt >= 2, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midburst_mem_drop", {mem_read, mem_write}, 2'b00);
    check("midburst_no_resp", {icache_pmem_resp, dcache_pmem_resp}, 2'b00);
    check("midburst_line_cleared", dcache_pmem_rdata, 256'h0);
    rst = 1'b0;
    dcache_pmem_read = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("post_reset_quiet", {mem_read, mem_write, icache_pmem_resp, dcache_pmem_resp}, 4'b0000);
    end
    check("abandoned_burst_unrecorded", done_q.size(), 0);
    icache_pmem_read    = 1'b1;
    icache_pmem_address = 32'h0000_0040;
    e = '{1'b0, 1'b0, 32'h0000_0040, L_I};
    exp_q.push_back(e);
    run_txns(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
